zoom_cmd_bridge: RTL and testbench

Upstream command stage for the zoom coprocessor core. It accepts host commands (opcode, address, data) through a valid/ready handshake and buffers them in a small FIFO. It replays each command into the core's level-style port set (INSTRUCTION, MEM_ADDR, DATA_IN, ENABLE), waits for the core's FLAG_DONE and returns one completion response per command with the core's DATA_OUT. It runs on the core's clk_100 domain.

---
 rtl/zoom_pkg.sv | 35 +++
 rtl/zoom_cmd_bridge_if.sv | 48 ++++
 rtl/zoom_cmd_bridge_cmd_fifo.sv | 63 ++++++
 rtl/zoom_cmd_bridge.sv | 173 +++++++++++++++++
 tb/tb_zoom_cmd_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zoom_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zoom_pkg
// Opcodes and command-entry types shared by the zoom core and its bridge.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package zoom_pkg;

  localparam int OPCODE_W = 3;
  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 8;

  localparam logic [OPCODE_W-1:0] NOP         = 3'd0;
  localparam logic [OPCODE_W-1:0] LOAD        = 3'd1;
  localparam logic [OPCODE_W-1:0] STORE       = 3'd2;
  localparam logic [OPCODE_W-1:0] ZOOM_IN_VP  = 3'd3;
  localparam logic [OPCODE_W-1:0] ZOOM_IN_RP  = 3'd4;
  localparam logic [OPCODE_W-1:0] ZOOM_OUT_MP = 3'd5;
  localparam logic [OPCODE_W-1:0] ZOOM_OUT_VD = 3'd6;
  localparam logic [OPCODE_W-1:0] RESET_INST  = 3'd7;

  // One buffered host command: 3 + 18 + 8 = 29 bits.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } cmd_entry_t;

  // RESET_INST gets no done from the core; NOP never reaches the core.
  function automatic logic waits_for_done(input logic [OPCODE_W-1:0] op);
    return (op != NOP) && (op != RESET_INST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zoom_cmd_bridge_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zoom_cmd_bridge_if
// Host command/response handshakes plus the level-style core port set.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface zoom_cmd_bridge_if;
  import zoom_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OPCODE_W-1:0] cmd_opcode;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_data;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [OPCODE_W-1:0] rsp_opcode;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_timeout;

  logic [OPCODE_W-1:0] core_instruction;
  logic [ADDR_W-1:0]   core_mem_addr;
  logic [DATA_W-1:0]   core_data_in;
  logic                core_enable;
  logic                core_done;
  logic [DATA_W-1:0]   core_data_out;

  logic                busy;

  // Host side together with the core it talks to.
  modport master (
    output cmd_valid, cmd_opcode, cmd_addr, cmd_data, rsp_ready,
    output core_done, core_data_out,
    input  cmd_ready, rsp_valid, rsp_opcode, rsp_data, rsp_timeout,
    input  core_instruction, core_mem_addr, core_data_in, core_enable, busy
  );

  // Bridge side.
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_addr, cmd_data, rsp_ready,
    input  core_done, core_data_out,
    output cmd_ready, rsp_valid, rsp_opcode, rsp_data, rsp_timeout,
    output core_instruction, core_mem_addr, core_data_in, core_enable, busy
  );

endinterface
`default_nettype wire

// File: rtl/zoom_cmd_bridge_cmd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous command FIFO with registered read data and a head-opcode peek.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module cmd_fifo
  import zoom_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              push,
  input  wire cmd_entry_t        wr_data,
  input  wire logic              pop,
  output cmd_entry_t             rd_data,
  output logic [OPCODE_W-1:0]    head_opcode,
  output logic                   full,
  output logic                   empty
);

  localparam int           AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  FULL_COUNT = (AW + 1)'(DEPTH);

  cmd_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered read port (held between pops).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  // Lets the FSM pick its next state in the same cycle it pops.
  assign head_opcode = mem[rd_ptr].opcode;

endmodule
`default_nettype wire

// File: rtl/zoom_cmd_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zoom_cmd_bridge
// Buffers host commands, replays them one at a time onto the zoom core's
// level-style ports and returns one completion per command.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module zoom_cmd_bridge
  import zoom_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int ENABLE_HOLD    = 2,
  parameter int RESET_WAIT     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input wire logic         clk,
  input wire logic         reset_n,
  zoom_cmd_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    CAPTURE   = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  localparam int          CNT_W        = 21;
  localparam logic [20:0] HOLD_LAST    = CNT_W'(ENABLE_HOLD - 1);
  localparam logic [20:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // The ISSUE->WAIT_DONE hop and the RESPOND cycle absorb part of the wait.
  localparam logic [20:0] RESET_LAST   = CNT_W'((RESET_WAIT > 1) ? RESET_WAIT - 2 : 0);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic                done_prev_q;
  logic                timed_out_q;
  logic [DATA_W-1:0]   cap_data_q;
  logic                rsp_valid_q;
  logic [OPCODE_W-1:0] rsp_opcode_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_timeout_q;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [OPCODE_W-1:0] head_opcode;
  cmd_entry_t          cur;
  cmd_entry_t          wr_entry;
  logic                done_edge;
  logic                timeout_hit;
  logic                is_reset_cmd;

  assign wr_entry     = '{opcode: bus.cmd_opcode, addr: bus.cmd_addr, data: bus.cmd_data};
  assign fifo_push    = bus.cmd_valid && !fifo_full;
  assign done_edge    = bus.core_done && !done_prev_q;
  assign is_reset_cmd = (cur.opcode == RESET_INST);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (fifo_push),
    .wr_data     (wr_entry),
    .pop         (fifo_pop),
    .rd_data     (cur),
    .head_opcode (head_opcode),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Next-state decode and pop request.
  always_comb begin
    state_next  = state;
    fifo_pop    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !rsp_valid_q) begin
          fifo_pop   = 1'b1;
          state_next = (head_opcode == NOP) ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == HOLD_LAST) begin
          if (is_reset_cmd && (RESET_WAIT <= 1)) state_next = RESPOND;
          else                                   state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (is_reset_cmd) begin
          if (cnt == RESET_LAST) state_next = RESPOND;
        end else if (done_edge) begin
          state_next = CAPTURE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RESPOND;
        end
      end
      CAPTURE: state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Shared hold/wait/timeout counter: cleared on every state entry, saturating.
  always_ff @(posedge clk) begin
    if (!reset_n)                 cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (cnt != '1)           cnt <= cnt + 1'b1;
  end

  // Previous core_done level, so only a fresh rising edge counts as completion.
  always_ff @(posedge clk) begin
    if (!reset_n) done_prev_q <= 1'b0;
    else          done_prev_q <= bus.core_done;
  end

  // Per-command result: captured read data and the timeout flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_data_q  <= '0;
      timed_out_q <= 1'b0;
    end else if (fifo_pop) begin
      cap_data_q  <= '0;
      timed_out_q <= 1'b0;
    end else begin
      // DATA_OUT is valid the cycle after done, which is the CAPTURE cycle.
      if (state == CAPTURE && cur.opcode == LOAD) cap_data_q <= bus.core_data_out;
      if (timeout_hit) timed_out_q <= 1'b1;
    end
  end

  // Response register, held until the host takes it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_opcode_q  <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (state == RESPOND) begin
      rsp_valid_q   <= 1'b1;
      rsp_opcode_q  <= cur.opcode;
      rsp_data_q    <= cap_data_q;
      rsp_timeout_q <= timed_out_q;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign bus.cmd_ready        = !fifo_full;
  assign bus.core_instruction = cur.opcode;
  assign bus.core_mem_addr    = cur.addr;
  assign bus.core_data_in     = cur.data;
  assign bus.core_enable      = (state == ISSUE);
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_opcode       = rsp_opcode_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_timeout      = rsp_timeout_q;
  assign bus.busy             = (state != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_zoom_cmd_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_zoom_cmd_bridge
// Scoreboard bench for zoom_cmd_bridge with a behavioural zoom-core model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_zoom_cmd_bridge;
  import zoom_pkg::*;

  localparam int HOLD  = 2;
  localparam int RW    = 2;
  localparam int TMO   = 64;
  localparam int DEPTH = 4;

  localparam int M_NORMAL = 0;  // done rises lat cycles after enable
  localparam int M_NEVER  = 1;  // done never rises
  localparam int M_STALE  = 2;  // done held high, dropped, re-raised

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic       tmo;
  } rsp_t;

  typedef struct {
    logic [2:0]  op;
    logic [17:0] addr;
    logic [7:0]  wdata;
    int          mode;
    int          lat;
    logic [7:0]  rdata;
  } plan_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   en_rises = 0;
  int   last_en_rise = -1;
  int   done_rise = -1;
  int   rr_mode = 1;
  rsp_t  exp_q[$];
  plan_t plan_q[$];

  zoom_cmd_bridge_if bus_if ();

  zoom_cmd_bridge #(
    .FIFO_DEPTH     (DEPTH),
    .ENABLE_HOLD    (HOLD),
    .RESET_WAIT     (RW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected completion straight from the command rules.
  function automatic rsp_t model_rsp(input plan_t p);
    rsp_t r;
    r.op   = p.op;
    r.tmo  = waits_for_done(p.op) && (p.mode == M_NEVER);
    r.data = (p.op == LOAD && !r.tmo) ? p.rdata : 8'h00;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one command; called and returns at posedge+1.
  task automatic send(input plan_t p, output int t);
    int waited;
    waited = 0;
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_opcode = p.op;
    bus_if.cmd_addr   = p.addr;
    bus_if.cmd_data   = p.wdata;
    while (!bus_if.cmd_ready && waited < 500) begin step(1); waited++; end
    if (!bus_if.cmd_ready) begin
      chk("cmd_accept_wait", 32'(bus_if.cmd_ready), 32'd1);
      bus_if.cmd_valid = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    exp_q.push_back(model_rsp(p));
    if (p.op != NOP) plan_q.push_back(p);
    step(1);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) begin c = cyc; break; end
    end
    if (c < 0) chk("rsp_wait", 32'(bus_if.rsp_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_if.busy) && n < limit) begin step(1); n++; end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic plan_t mk(input logic [2:0] op, input int mode, input int lat);
    plan_t p;
    p.op = op; p.addr = 18'($urandom); p.wdata = 8'($urandom);
    p.mode = mode; p.lat = lat; p.rdata = 8'($urandom);
    return p;
  endfunction

  // Core behaviour for one enabled command.
  task automatic run_core(input plan_t p);
    if (p.mode == M_NEVER) begin
      bus_if.core_done = 1'b0;
    end else if (p.mode == M_STALE) begin
      bus_if.core_done = 1'b1;
      step(p.lat);
      bus_if.core_done = 1'b0;
      step(2);
      bus_if.core_done = 1'b1;
      bus_if.core_data_out = ~p.rdata;
      done_rise = cyc;
      step(1);
      bus_if.core_data_out = p.rdata;
    end else begin
      bus_if.core_done = 1'b0;
      step(p.lat);
      bus_if.core_done = 1'b1;
      bus_if.core_data_out = ~p.rdata;
      done_rise = cyc;
      step(1);
      bus_if.core_data_out = p.rdata;
    end
  endtask

  // Core model: reacts to each enable rise with the next planned command.
  initial begin
    logic  en_prev;
    plan_t p;
    en_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && bus_if.core_enable && !en_prev) begin
        en_rises++;
        last_en_rise = cyc;
        if (plan_q.size() == 0) begin
          chk("unexpected_enable", 32'(bus_if.core_instruction), 32'hFFFF_FFFF);
        end else begin
          p = plan_q.pop_front();
          chk("core_instruction", 32'(bus_if.core_instruction), 32'(p.op));
          chk("core_mem_addr", 32'(bus_if.core_mem_addr), 32'(p.addr));
          chk("core_data_in", 32'(bus_if.core_data_in), 32'(p.wdata));
          if (p.op != RESET_INST) run_core(p);
        end
      end
      en_prev = bus_if.core_enable;
    end
  end

  // Every enable pulse must last exactly the hold length.
  int en_run = 0;
  always @(negedge clk) begin
    if (bus_if.core_enable) en_run++;
    else begin
      if (en_run != 0) chk("enable_width", 32'(en_run), 32'(HOLD));
      en_run = 0;
    end
  end

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (bus_if.rsp_valid && bus_if.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(bus_if.rsp_opcode), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_opcode", 32'(bus_if.rsp_opcode), 32'(e.op));
        chk("rsp_data", 32'(bus_if.rsp_data), 32'(e.data));
        chk("rsp_timeout", 32'(bus_if.rsp_timeout), 32'(e.tmo));
      end
    end
  end

  // rsp_ready: 0 = held low, 1 = held high, 2 = random.
  initial begin
    bus_if.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus_if.rsp_ready = 1'b0;
        1:       bus_if.rsp_ready = 1'b1;
        default: bus_if.rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t p;
    int    t;
    int    c;
    int    e0;
    bus_if.cmd_valid     = 1'b0;
    bus_if.cmd_opcode    = '0;
    bus_if.cmd_addr      = '0;
    bus_if.cmd_data      = '0;
    bus_if.core_done     = 1'b0;
    bus_if.core_data_out = '0;

    step(3);
    chk("reset_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("reset_busy", 32'(bus_if.busy), 32'd0);
    chk("reset_enable", 32'(bus_if.core_enable), 32'd0);
    chk("reset_instr", 32'(bus_if.core_instruction), 32'd0);
    reset_n = 1'b1;
    step(2);

    // LOAD with done 10 cycles after the enable edge, DATA_OUT=0x5A.
    p = mk(LOAD, M_NORMAL, 10);
    p.addr = 18'h00123; p.rdata = 8'h5A;
    send(p, t);
    wait_rsp(200, c);
    chk("load_enable_start", 32'(last_en_rise), 32'(t + 2));
    chk("load_rsp_latency", 32'(c >= done_rise + 2 && c <= done_rise + 3), 32'd1);
    drain(100);

    // NOP: no enable, response two cycles after the pop.
    e0 = en_rises;
    send(mk(NOP, M_NORMAL, 3), t);
    wait_rsp(50, c);
    chk("nop_rsp_time", 32'(c), 32'(t + 3));
    chk("nop_no_enable", 32'(en_rises), 32'(e0));
    drain(50);

    // RESET_INST with done never asserted.
    send(mk(RESET_INST, M_NEVER, 3), t);
    wait_rsp(50, c);
    chk("reset_inst_enable", 32'(last_en_rise), 32'(t + 2));
    chk("reset_inst_rsp_time", 32'(c), 32'(t + 1 + HOLD + RW + 1));
    drain(50);

    // Stale done level: leave done high, then issue ZOOM_IN_RP.
    send(mk(STORE, M_NORMAL, 4), t);
    drain(100);
    send(mk(ZOOM_IN_RP, M_STALE, 6), t);
    wait_rsp(200, c);
    chk("stale_done_ignored", 32'(c >= done_rise + 2 && c <= done_rise + 3), 32'd1);
    drain(100);

    // Five STOREs with rsp_ready low: the first is popped at once, the
    // remaining four fill the FIFO and only one command reaches the core.
    rr_mode = 0;
    step(1);
    e0 = en_rises;
    for (int i = 0; i < 5; i++) send(mk(STORE, M_NORMAL, $urandom_range(3, 6)), t);
    chk("fifo_full_ready", 32'(bus_if.cmd_ready), 32'd0);
    step(40);
    chk("one_in_flight", 32'(en_rises - e0), 32'd1);
    chk("rsp_held", 32'(bus_if.rsp_valid), 32'd1);
    rr_mode = 1;
    drain(500);

    // Timeout, then a queued LOAD still issues normally.
    send(mk(ZOOM_OUT_MP, M_NEVER, 3), t);
    send(mk(LOAD, M_NORMAL, 5), t);
    wait_rsp(300, c);
    chk("timeout_rsp_time", 32'(c), 32'(last_en_rise + HOLD + TMO + 1));
    drain(300);

    // Reset while waiting for done: command is dropped.
    send(mk(ZOOM_IN_VP, M_NEVER, 3), t);
    step(8);
    reset_n = 1'b0;
    step(1);
    chk("midreset_enable", 32'(bus_if.core_enable), 32'd0);
    chk("midreset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("midreset_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("midreset_busy", 32'(bus_if.busy), 32'd0);
    exp_q.delete();
    plan_q.delete();
    reset_n = 1'b1;
    step(2);

    // Randomized traffic with random response back-pressure.
    rr_mode = 2;
    for (int i = 0; i < 30; i++) begin
      int mode;
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       mode = M_NEVER;
        1:       mode = M_STALE;
        default: mode = M_NORMAL;
      endcase
      send(mk(op, mode, $urandom_range(3, 12)), t);
      step($urandom_range(0, 3));
    end
    rr_mode = 1;
    drain(5000);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("core_plan_empty", 32'(plan_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
